// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD mode scheduler and the text LCD controller:
// one-hot mode codes, scheduler states, LCD character codes and BCD helpers.
package lcd_pkg;

    localparam logic [3:0] MODE_CLOCK = 4'b1000;
    localparam logic [3:0] MODE_SET   = 4'b0100;
    localparam logic [3:0] MODE_SW    = 4'b0010;
    localparam logic [3:0] MODE_ALARM = 4'b0001;

    typedef enum logic [1:0] {
        ST_CLOCK = 2'd0,
        ST_SET   = 2'd1,
        ST_SW    = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [7:0] LCD_CHAR_SPACE = 8'h20;
    localparam logic [7:0] LCD_CHAR_COLON = 8'h3A;
    localparam logic [7:0] LCD_CHAR_ZERO  = 8'h30;

    function automatic logic bcd_valid(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic [3:0] mode_code(input state_t s);
        logic [3:0] m;
        case (s)
            ST_CLOCK: m = MODE_CLOCK;
            ST_SET:   m = MODE_SET;
            ST_SW:    m = MODE_SW;
            ST_ALARM: m = MODE_ALARM;
            default:  m = MODE_CLOCK;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/key_filter.sv
// Two-flop synchronizer plus stability filter for a raw push button; emits a
// single-cycle press pulse once the key has been stably high for KEY_FILTER cycles.
module key_filter #(
    parameter int KEY_FILTER = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);

    localparam int CW = (KEY_FILTER > 1) ? $clog2(KEY_FILTER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(KEY_FILTER - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;
    logic          change_s;

    // The accepted level flips on the cycle the counter completes its run.
    assign change_s = (sync2_r != level_r) && (cnt_r == CNT_LAST);
    assign press    = change_s & sync2_r;

    // Synchronizer, stability counter and accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            sync1_r <= key;
            sync2_r <= sync1_r;
            if (sync2_r == level_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (change_s) begin
                level_r <= sync2_r;
                cnt_r   <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: rtl/lcd_mode_scheduler.sv
// Chooses which display mode owns the text LCD and which BCD time source feeds it,
// with debounced mode cycling, alarm pre-emption/timeout and BCD sanity checking.
module lcd_mode_scheduler
    import lcd_pkg::*;
#(
    parameter int KEY_FILTER = 3,
    parameter int ALARM_HOLD = 5000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       mode_key,
    input  logic       alarm_req,
    input  logic [7:0] clk_h,
    input  logic [7:0] clk_m,
    input  logic [7:0] clk_s,
    input  logic [7:0] set_h,
    input  logic [7:0] set_m,
    input  logic [7:0] set_s,
    input  logic [7:0] sw_h,
    input  logic [7:0] sw_m,
    input  logic [7:0] sw_s,
    output logic [3:0] enable,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       alarm_ack,
    output logic       bcd_err
);

    localparam int HW = $clog2(ALARM_HOLD);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(ALARM_HOLD - 1);

    state_t        state_r, state_n;
    state_t        saved_r, saved_n;
    logic [HW-1:0] hold_r, hold_n;
    logic          ack_r, ack_n;
    logic          press_s;
    logic          alarm_sync1_r, alarm_sync2_r, alarm_prev_r;
    logic          alarm_pulse_s;
    logic [7:0]    src_h_s, src_m_s, src_s_s;
    logic [3:0]    enable_r;
    logic [7:0]    hour_r, minute_r, second_r;
    logic          bcd_err_r;

    key_filter #(.KEY_FILTER(KEY_FILTER)) u_key_filter (
        .clk   (clk),
        .rst_n (resetn),
        .key   (mode_key),
        .press (press_s)
    );

    assign alarm_pulse_s = alarm_sync2_r & ~alarm_prev_r;

    // Alarm request synchronizer and rising-edge history.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alarm_sync1_r <= 1'b0;
            alarm_sync2_r <= 1'b0;
            alarm_prev_r  <= 1'b0;
        end else begin
            alarm_sync1_r <= alarm_req;
            alarm_sync2_r <= alarm_sync1_r;
            alarm_prev_r  <= alarm_sync2_r;
        end
    end

    // Mode FSM next-state; an alarm pulse outranks a simultaneous press.
    always_comb begin
        state_n = state_r;
        saved_n = saved_r;
        hold_n  = hold_r;
        ack_n   = 1'b0;
        if (alarm_pulse_s) begin
            state_n = ST_ALARM;
            hold_n  = HOLD_LOAD;
            if (state_r != ST_ALARM) begin
                saved_n = state_r;
            end else begin
                saved_n = saved_r;
            end
        end else begin
            case (state_r)
                ST_CLOCK: if (press_s) state_n = ST_SET;   else state_n = ST_CLOCK;
                ST_SET:   if (press_s) state_n = ST_SW;    else state_n = ST_SET;
                ST_SW:    if (press_s) state_n = ST_CLOCK; else state_n = ST_SW;
                ST_ALARM: begin
                    if (press_s || (hold_r == {HW{1'b0}})) begin
                        state_n = saved_r;
                        ack_n   = 1'b1;
                    end else begin
                        hold_n = hold_r - HW'(1);
                    end
                end
                default:  state_n = ST_CLOCK;
            endcase
        end
    end

    // Mode FSM state, saved return mode, hold counter and acknowledge pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_CLOCK;
            saved_r <= ST_CLOCK;
            hold_r  <= {HW{1'b0}};
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            saved_r <= saved_n;
            hold_r  <= hold_n;
            ack_r   <= ack_n;
        end
    end

    // Time source select; the alarm screen shows the running clock.
    always_comb begin
        case (state_r)
            ST_SET: begin
                src_h_s = set_h; src_m_s = set_m; src_s_s = set_s;
            end
            ST_SW: begin
                src_h_s = sw_h;  src_m_s = sw_m;  src_s_s = sw_s;
            end
            default: begin
                src_h_s = clk_h; src_m_s = clk_m; src_s_s = clk_s;
            end
        endcase
    end

    // Output registers; an invalid byte keeps its last good value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enable_r  <= 4'b0000;
            hour_r    <= 8'h00;
            minute_r  <= 8'h00;
            second_r  <= 8'h00;
            bcd_err_r <= 1'b0;
        end else begin
            enable_r <= mode_code(state_r);
            if (bcd_valid(src_h_s)) hour_r   <= src_h_s;
            if (bcd_valid(src_m_s)) minute_r <= src_m_s;
            if (bcd_valid(src_s_s)) second_r <= src_s_s;
            bcd_err_r <= bcd_err_r | ~(bcd_valid(src_h_s) & bcd_valid(src_m_s) & bcd_valid(src_s_s));
        end
    end

    assign enable    = enable_r;
    assign hour      = hour_r;
    assign minute    = minute_r;
    assign second    = second_r;
    assign alarm_ack = ack_r;
    assign bcd_err   = bcd_err_r;

endmodule

// File: tb/tb_lcd_mode_scheduler.sv
// Scoreboard bench for lcd_mode_scheduler: stimulus queues cycle-stamped expectations,
// a monitor pops and compares them as the outputs are presented.
module tb_lcd_mode_scheduler;

    localparam logic [7:0] CH = 8'h12, CM = 8'h34, CS = 8'h56;
    localparam logic [7:0] SH = 8'h07, SM = 8'h48, SS = 8'h19;
    localparam logic [7:0] WH = 8'h01, WM = 8'h23, WS = 8'h45;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] en;
        logic [7:0] h, m, s;
        logic       ack, err;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       mode_key = 1'b0, alarm_req = 1'b0;
    logic [7:0] clk_h = CH, clk_m = CM, clk_s = CS;
    logic [7:0] set_h = SH, set_m = SM, set_s = SS;
    logic [7:0] sw_h = WH, sw_m = WM, sw_s = WS;
    logic [3:0] enable;
    logic [7:0] hour, minute, second;
    logic       alarm_ack, bcd_err;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;
    logic finish_req = 1'b0;

    lcd_mode_scheduler #(.KEY_FILTER(3), .ALARM_HOLD(10)) dut (
        .clk(clk), .resetn(resetn), .mode_key(mode_key), .alarm_req(alarm_req),
        .clk_h(clk_h), .clk_m(clk_m), .clk_s(clk_s),
        .set_h(set_h), .set_m(set_m), .set_s(set_s),
        .sw_h(sw_h), .sw_m(sw_m), .sw_s(sw_s),
        .enable(enable), .hour(hour), .minute(minute), .second(second),
        .alarm_ack(alarm_ack), .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int c, input string nm, input logic [3:0] en, input logic ack);
        exp_t e;
        e.cyc = c; e.name = nm; e.en = en; e.ack = ack; e.err = exp_err;
        case (en)
            4'b1000, 4'b0001: begin e.h = CH; e.m = CM; e.s = CS; end
            4'b0100:          begin e.h = SH; e.m = SM; e.s = SS; end
            4'b0010:          begin e.h = WH; e.m = WM; e.s = WS; end
            default:          begin e.h = 8'h00; e.m = 8'h00; e.s = 8'h00; end
        endcase
        return e;
    endfunction

    task automatic push(input exp_t e);
        int i;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
        sb.insert(i, e);
    endtask

    task automatic compare(input exp_t e);
        checks++;
        if ({enable, hour, minute, second, alarm_ack, bcd_err} !== {e.en, e.h, e.m, e.s, e.ack, e.err}) begin
            errors++;
            $display("FAIL %s @cyc %0d: got en=%b h=%h m=%h s=%h ack=%b err=%b, want en=%b h=%h m=%h s=%h ack=%b err=%b",
                     e.name, cyc, enable, hour, minute, second, alarm_ack, bcd_err,
                     e.en, e.h, e.m, e.s, e.ack, e.err);
        end
    endtask

    // Monitor: posedge wakeups compare cycle-stamped entries, reset wakeups compare immediate ones.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge resetn);
            #1;
            if (clk) begin
                cyc++;
                while (sb.size() > 0 && sb[0].cyc >= 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    compare(e);
                end
                if (finish_req) begin
                    while (sb.size() > 0) begin
                        e = sb.pop_front();
                        checks++;
                        errors++;
                        $display("FAIL %s: expectation never reached (cyc %0d)", e.name, e.cyc);
                    end
                    $display("CHECKS %0d ERRORS %0d", checks, errors);
                    $finish;
                end
            end else begin
                while (sb.size() > 0 && sb[0].cyc == -1) begin
                    e = sb.pop_front();
                    compare(e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] from, input logic [3:0] to, input string nm, input int hi);
        int t;
        t = cyc;
        mode_key = 1'b1;
        push(mk(t + 5, {nm, "_pre"}, from, 1'b0));
        push(mk(t + 6, nm, to, 1'b0));
        push(mk(t + hi + 2, {nm, "_once"}, to, 1'b0));
        step(hi);
        mode_key = 1'b0;
        step(7);
    endtask

    // Directed stimulus.
    initial begin
        int   t;
        exp_t e;
        push(mk(2, "rst_hold_a", 4'b0000, 1'b0));
        push(mk(4, "rst_hold_b", 4'b0000, 1'b0));
        step(5);
        resetn = 1'b1;
        push(mk(6, "rst_release", 4'b1000, 1'b0));
        push(mk(8, "clock_idle", 4'b1000, 1'b0));
        step(4);

        press(4'b1000, 4'b0100, "press_to_set", 10);

        t = cyc;
        mode_key = 1'b1;
        step(2);
        mode_key = 1'b0;
        push(mk(t + 8, "glitch_ignored", 4'b0100, 1'b0));
        step(10);

        press(4'b0100, 4'b0010, "press_to_sw", 5);
        press(4'b0010, 4'b1000, "press_to_clock", 5);
        press(4'b1000, 4'b0100, "press_to_set2", 5);
        press(4'b0100, 4'b0010, "press_to_sw2", 5);

        t = cyc;
        alarm_req = 1'b1;
        push(mk(t + 3,  "alarm_pre", 4'b0010, 1'b0));
        push(mk(t + 4,  "alarm_enter", 4'b0001, 1'b0));
        push(mk(t + 12, "alarm_still", 4'b0001, 1'b0));
        push(mk(t + 13, "alarm_ack_timeout", 4'b0001, 1'b1));
        push(mk(t + 14, "alarm_return_sw", 4'b0010, 1'b0));
        push(mk(t + 20, "alarm_level_no_retrig", 4'b0010, 1'b0));
        step(22);
        alarm_req = 1'b0;
        step(4);

        t = cyc;
        alarm_req = 1'b1;
        push(mk(t + 4, "alarm2_enter", 4'b0001, 1'b0));
        step(5);
        mode_key = 1'b1;
        push(mk(t + 10, "dismiss_ack", 4'b0001, 1'b1));
        push(mk(t + 11, "dismiss_return_sw", 4'b0010, 1'b0));
        push(mk(t + 18, "dismiss_no_advance", 4'b0010, 1'b0));
        step(5);
        mode_key = 1'b0;
        alarm_req = 1'b0;
        step(12);

        press(4'b0010, 4'b1000, "press_to_clock2", 5);

        t = cyc;
        mode_key = 1'b1;
        step(2);
        alarm_req = 1'b1;
        push(mk(t + 6,  "collide_alarm", 4'b0001, 1'b0));
        push(mk(t + 12, "collide_no_dismiss", 4'b0001, 1'b0));
        push(mk(t + 15, "collide_ack", 4'b0001, 1'b1));
        push(mk(t + 16, "collide_return_clock", 4'b1000, 1'b0));
        step(3);
        mode_key = 1'b0;
        step(14);
        alarm_req = 1'b0;
        step(4);

        press(4'b1000, 4'b0100, "press_to_set3", 5);

        t = cyc;
        exp_err = 1'b1;
        set_m = 8'h3A;
        set_s = 8'h11;
        e = mk(t + 1, "bcd_hold_minute", 4'b0100, 1'b0);
        e.s = 8'h11;
        push(e);
        step(1);
        set_m = SM;
        set_s = SS;
        push(mk(t + 2, "bcd_err_sticky", 4'b0100, 1'b0));
        push(mk(t + 5, "bcd_err_sticky_late", 4'b0100, 1'b0));
        step(5);

        t = cyc;
        alarm_req = 1'b1;
        push(mk(t + 4, "alarm3_enter", 4'b0001, 1'b0));
        step(6);
        #2;
        exp_err = 1'b0;
        push(mk(-1, "async_reset_now", 4'b0000, 1'b0));
        push(mk(t + 8, "async_reset_hold", 4'b0000, 1'b0));
        resetn = 1'b0;
        alarm_req = 1'b0;
        step(3);
        resetn = 1'b1;
        push(mk(t + 10, "post_reset_clock", 4'b1000, 1'b0));
        push(mk(t + 14, "post_reset_no_ack", 4'b1000, 1'b0));
        step(8);
        finish_req = 1'b1;
    end

endmodule

// File: doc/lcd_mode_scheduler.md
Name: lcd_mode_scheduler

Overview:
- Decides which display mode owns the 16x2 text LCD controller, and which BCD time source feeds it.
- Sources: a user mode key and an alarm request. Output is a one-hot mode code on `enable`, plus the matching hour/minute/second BCD bytes, all driven to the text LCD controller.
- Sits between the timekeeping blocks (clock, set-clock, stopwatch) and the LCD controller.
- Provides debounced mode cycling, alarm pre-emption with a timed hold and return-to-previous-mode, and BCD sanity checking.

Parameters:
- KEY_FILTER, 3: consecutive synchronized cycles a key level must be stable before it is accepted (min 1).
- ALARM_HOLD, 5000: cycles the ALARM mode is shown before automatic return (min 2).

Ports:
- `clk`  in  1  system clock, same clock as the LCD controller.
- `resetn`  in  1  reset, asynchronous, active-low.
- `mode_key`  in  1  raw push button, active-high, asynchronous to `clk`.
- `alarm_req`  in  1  alarm match level from the alarm block, asynchronous.
- `clk_h`, `clk_m`, `clk_s`  in  8 each  running clock time, BCD [7:4] tens, [3:0] units.
- `set_h`, `set_m`, `set_s`  in  8 each  time being edited.
- `sw_h`, `sw_m`, `sw_s`  in  8 each  stopwatch value.
- `enable`  out  4  one-hot mode to the LCD: 1000 CLOCK, 0100 SET, 0010 STOPWATCH, 0001 ALARM.
- `hour`, `minute`, `second`  out  8 each  selected BCD time to the LCD.
- `alarm_ack`  out  1  one-cycle pulse when ALARM mode is left.
- `bcd_err`  out  1  sticky flag: an invalid BCD source was seen.

Behaviour:
- **Reset (`resetn` low, async):**
  - State is CLOCK, saved-return state is CLOCK, hold counter is 0, and the filter counters and synchronizers are 0.
  - Outputs: `enable`=0000, `hour`/`minute`/`second`=8'h00, `alarm_ack`=0, `bcd_err`=0.
  - First posedge after release: `enable`=1000.
  - Reset mid-alarm drops the alarm without asserting `alarm_ack`.
- **Synchronization:** `mode_key` and `alarm_req` each pass through 2 flops before any use.
- **Key filter:**
  - The synced key must be high for KEY_FILTER consecutive cycles; this produces exactly one press pulse.
  - It re-arms only after KEY_FILTER consecutive low cycles. Glitches shorter than KEY_FILTER are ignored.
  - Latency from the raw edge to the press pulse is 2 + KEY_FILTER cycles.
- **Alarm detect:** a rising edge of synced `alarm_req` produces a single alarm pulse. A held-high level does not re-trigger.
- **FSM states:** CLOCK, SET, STOPWATCH, ALARM.
  - A press cycles CLOCK -> SET -> STOPWATCH -> CLOCK.
  - An alarm pulse in any non-ALARM state saves the current state, enters ALARM and loads hold = ALARM_HOLD-1.
  - In ALARM, hold decrements by 1 per cycle. When hold = 0, or on a press, return to the saved state and pulse `alarm_ack` for 1 cycle.
  - A press in ALARM is consumed and does not also advance the mode.
  - An alarm pulse while in ALARM reloads hold and keeps the saved state.
  - An alarm pulse and a press in the same cycle: the alarm wins and the press is discarded.
- **Output registers:** `enable`, `hour`, `minute`, `second` are registered, updating 1 cycle after the state changes.
  - Source select: CLOCK and ALARM use `clk_*`; SET uses `set_*`; STOPWATCH uses `sw_*`.
  - Outputs refresh every cycle from the selected source (pass-through with 1-cycle latency).
- **BCD check:**
  - If any nibble of the selected source byte is >9, that output byte holds its previous value and `bcd_err` sets.
  - The other two bytes still update.
  - `bcd_err` clears only on reset.
- **Range:** no range check of tens digits (e.g. 8'h25 hours passes through); that is the source blocks' responsibility.

Decomposition:
- Shared package `lcd_pkg`:
  - enable/mode one-hot constants (MODE_CLOCK 4'b1000, MODE_SET 4'b0100, MODE_SW 4'b0010, MODE_ALARM 4'b0001);
  - FSM state typedef;
  - `bcd_valid(byte)` function;
  - LCD character constants used by the LCD controller.
- One sub-module `key_filter` (2-flop sync + KEY_FILTER stability counter + press pulse). It is instantiated once for the key; the alarm path uses only the sync + edge logic inline.

Test Plan:
- **Reset and default mode:** hold `resetn` low 5 cycles with `clk_h/m/s`=12/34/56 -> `enable`=0000 and outputs 00 during reset. One cycle after release: `enable`=1000, `hour`=8'h12, `minute`=8'h34, `second`=8'h56.
- **Mode cycling and filter:** hold `mode_key` high 10 cycles (KEY_FILTER=3) -> `enable` 1000->0100 exactly once, 6 cycles after the raw edge, with `hour` now from `set_h`. A 2-cycle glitch causes no change. Two further clean presses give 0010 then 1000.
- **Alarm pre-emption and timeout:** in STOPWATCH with ALARM_HOLD=10, rise `alarm_req` -> `enable`=0001 showing `clk_*`. After 10 cycles in ALARM it returns to 0010, with a 1-cycle `alarm_ack`.
- **Alarm dismiss and collision:**
  - Press during ALARM -> return to the saved mode, `alarm_ack` pulses, mode not advanced.
  - Alarm pulse and press in the same cycle from CLOCK -> `enable`=0001, press lost.
- **Invalid BCD:** in SET, drive `set_m`=8'h3A for 1 cycle with `set_h`=8'h07 -> `minute` holds its prior value, `hour`=8'h07, `bcd_err`=1 and stays 1 after `set_m` returns to valid.
- **Async reset mid-alarm:** assert `resetn` low between clock edges while in ALARM -> outputs clear immediately and `alarm_ack` stays 0. After release, CLOCK mode resumes.
